matrix_sequencer: RTL and testbench

MATRIX_SEQUENCER -- requirements
Module: matrix_sequencer

---
 rtl/matrix_sequencer_pkg.sv | 47 ++++
 rtl/matrix_sequencer_if.sv | 36 +++
 rtl/matrix_sequencer_seq_watchdog.sv | 30 +++
 rtl/matrix_sequencer.sv | 153 +++++++++++++++
 tb/tb_matrix_sequencer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/matrix_sequencer_pkg.sv
// Shared definitions for the matrix sequencer: opcodes, FSM states and
// instruction field positions.
package matrix_sequencer_pkg;

  localparam int INSTR_W   = 27;
  localparam int ADDR_W    = 4;
  localparam int FIELD_W   = 7;
  localparam int SCALAR_W  = 8;
  localparam int RETIRED_W = 5;

  localparam int OPC_MSB    = 26;
  localparam int OPC_LSB    = 22;
  localparam int DEST_MSB   = 21;
  localparam int DEST_LSB   = 15;
  localparam int SRC1_MSB   = 14;
  localparam int SRC1_LSB   = 8;
  localparam int SRC2_MSB   = 7;
  localparam int SRC2_LSB   = 1;
  localparam int SCALAR_MSB = 7;
  localparam int SCALAR_LSB = 0;

  typedef enum logic [4:0] {
    OP_NOP       = 5'b00000,
    OP_ADD       = 5'b00001,
    OP_SUB       = 5'b00010,
    OP_MULT      = 5'b00011,
    OP_SCALE     = 5'b00100,
    OP_TRANSPOSE = 5'b00101,
    OP_HALT      = 5'b11111
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_READ   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  function automatic logic is_unit_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MULT) ||
           (op == OP_SCALE) || (op == OP_TRANSPOSE);
  endfunction

endpackage

// File: rtl/matrix_sequencer_if.sv
// Instruction-memory, data-memory and math-unit signals of the sequencer.
interface matrix_sequencer_if;
  import matrix_sequencer_pkg::*;

  // Handshake: the sequencer holds exactly one en_* high for the whole EXEC
  // state; the unit raises unit_done when its result is ready and the
  // sequencer leaves EXEC on the first edge that samples unit_done high.
  // unit_done is ignored while no enable is high.
  logic [ADDR_W-1:0]   instr_addr;
  logic [INSTR_W-1:0]  instr;
  logic [FIELD_W-1:0]  src1_addr;
  logic [FIELD_W-1:0]  src2_addr;
  logic [FIELD_W-1:0]  dest_addr;
  logic [SCALAR_W-1:0] scalar;
  logic                mem_rd;
  logic                mem_wr;
  logic                en_add;
  logic                en_mult;
  logic                en_scale;
  logic                en_transpose;
  logic                add_or_sub;
  logic                unit_done;

  modport master (
    output instr_addr, src1_addr, src2_addr, dest_addr, scalar,
           mem_rd, mem_wr, en_add, en_mult, en_scale, en_transpose, add_or_sub,
    input  instr, unit_done
  );

  modport slave (
    input  instr_addr, src1_addr, src2_addr, dest_addr, scalar,
           mem_rd, mem_wr, en_add, en_mult, en_scale, en_transpose, add_or_sub,
    output instr, unit_done
  );

endinterface

// File: rtl/matrix_sequencer_seq_watchdog.sv
// EXEC timeout counter: load arms it, each tick consumes one cycle, expire
// flags the last allowed cycle.
module seq_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  // Loaded with TIMEOUT-1 so the count reads zero on the TIMEOUT-th cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(TIMEOUT - 1);
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/matrix_sequencer.sv
// Instruction sequencer for the matrix engine: fetches, decodes and steps
// each instruction through read / execute / write with registered strobes.
module matrix_sequencer
  import matrix_sequencer_pkg::*;
#(
  parameter int EXEC_TIMEOUT = 16,
  parameter int LAST_ADDR    = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault,
  output logic [RETIRED_W-1:0] retired,
  output state_t               dbg_state,
  matrix_sequencer_if.master   bus
);

  state_t                 state, state_n;
  logic [ADDR_W-1:0]      pc, pc_n;
  logic [RETIRED_W-1:0]   retired_q, retired_n;
  logic                   fault_q, fault_n;
  logic [4:0]             op_q;
  logic [4:0]             opcode;
  logic                   latch;
  logic                   wd_load, wd_tick, wd_expire;

  assign opcode = bus.instr[OPC_MSB:OPC_LSB];

  seq_watchdog #(.TIMEOUT(EXEC_TIMEOUT)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .load   (wd_load),
    .tick   (wd_tick),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    retired_n = retired_q;
    fault_n   = fault_q;
    latch     = 1'b0;
    wd_load   = 1'b0;
    wd_tick   = 1'b0;
    unique case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_n   = ST_FETCH;
          pc_n      = '0;
          retired_n = '0;
          fault_n   = 1'b0;
        end
      end
      ST_FETCH: state_n = ST_DECODE;
      ST_DECODE: begin
        latch = 1'b1;
        if (opcode == OP_NOP) begin
          retired_n = retired_q + 1'b1;
          if (pc == ADDR_W'(LAST_ADDR)) state_n = ST_HALT;
          else begin
            pc_n    = pc + 1'b1;
            state_n = ST_FETCH;
          end
        end else if (opcode == OP_HALT) begin
          state_n = ST_HALT;
        end else if (is_unit_op(opcode)) begin
          state_n = ST_READ;
        end else begin
          state_n = ST_HALT;
          fault_n = 1'b1;
        end
      end
      ST_READ: begin
        state_n = ST_EXEC;
        wd_load = 1'b1;
      end
      // unit_done is checked before expiry so a late result still retires.
      ST_EXEC: begin
        if (bus.unit_done) state_n = ST_WRITE;
        else if (wd_expire) begin
          state_n = ST_HALT;
          fault_n = 1'b1;
        end else wd_tick = 1'b1;
      end
      ST_WRITE: begin
        retired_n = retired_q + 1'b1;
        if (pc == ADDR_W'(LAST_ADDR)) state_n = ST_HALT;
        else begin
          pc_n    = pc + 1'b1;
          state_n = ST_FETCH;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each is high exactly
  // while the FSM sits in the matching state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc               <= '0;
      retired_q        <= '0;
      fault_q          <= 1'b0;
      op_q             <= '0;
      bus.src1_addr    <= '0;
      bus.src2_addr    <= '0;
      bus.dest_addr    <= '0;
      bus.scalar       <= '0;
      bus.mem_rd       <= 1'b0;
      bus.mem_wr       <= 1'b0;
      bus.en_add       <= 1'b0;
      bus.en_mult      <= 1'b0;
      bus.en_scale     <= 1'b0;
      bus.en_transpose <= 1'b0;
      bus.add_or_sub   <= 1'b0;
      busy             <= 1'b0;
      halted           <= 1'b0;
    end else begin
      pc        <= pc_n;
      retired_q <= retired_n;
      fault_q   <= fault_n;
      if (latch) begin
        op_q          <= opcode;
        bus.src1_addr <= bus.instr[SRC1_MSB:SRC1_LSB];
        bus.src2_addr <= bus.instr[SRC2_MSB:SRC2_LSB];
        bus.dest_addr <= bus.instr[DEST_MSB:DEST_LSB];
        bus.scalar    <= bus.instr[SCALAR_MSB:SCALAR_LSB];
      end
      bus.mem_rd       <= (state_n == ST_READ);
      bus.mem_wr       <= (state_n == ST_WRITE);
      bus.en_add       <= (state_n == ST_EXEC) && ((op_q == OP_ADD) || (op_q == OP_SUB));
      bus.en_mult      <= (state_n == ST_EXEC) && (op_q == OP_MULT);
      bus.en_scale     <= (state_n == ST_EXEC) && (op_q == OP_SCALE);
      bus.en_transpose <= (state_n == ST_EXEC) && (op_q == OP_TRANSPOSE);
      bus.add_or_sub   <= (state_n == ST_EXEC) && (op_q == OP_SUB);
      busy             <= (state_n != ST_IDLE) && (state_n != ST_HALT);
      halted           <= (state_n == ST_HALT);
    end
  end

  assign bus.instr_addr = pc;
  assign retired        = retired_q;
  assign fault          = fault_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_matrix_sequencer.sv
// Directed bench for matrix_sequencer with a registered instruction memory
// model and a programmable unit_done responder.
module tb_matrix_sequencer;
  import matrix_sequencer_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         busy, halted, fault;
  logic [4:0]   retired;
  state_t       dbg_state;
  logic [26:0]  imem [16];

  int n_pass  = 0;
  int n_total = 0;

  // Results captured by run_prog; cycle 1 is the cycle after the start edge.
  int         halt_cyc, first_rd, first_en, first_wr, n_rd, n_wr, n_en;
  logic [6:0] cap_dest, cap_src1, cap_src2;
  logic [7:0] cap_scalar;
  logic       cap_aos;

  matrix_sequencer_if bus ();

  matrix_sequencer #(.EXEC_TIMEOUT(16), .LAST_ADDR(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.instr <= imem[bus.instr_addr];

  function automatic logic [26:0] mk(input logic [4:0] op, input logic [6:0] d,
                                     input logic [6:0] s1, input logic [6:0] s2);
    return {op, d, s1, s2, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic fill(input logic [26:0] w);
    for (int i = 0; i < 16; i++) imem[i] = w;
  endtask

  function automatic logic en_any();
    return bus.en_add | bus.en_mult | bus.en_scale | bus.en_transpose;
  endfunction

  // Call at a negedge. done_at: EXEC cycle on which unit_done is raised (0 = never).
  // stray: level driven on unit_done outside EXEC. start_at: cycle of an extra start pulse.
  task automatic run_prog(input int done_at, input logic stray, input int start_at, input int budget);
    int c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1; first_rd = 0; first_en = 0; first_wr = 0; n_rd = 0; n_wr = 0; n_en = 0;
    while ((c <= budget) && !halted) begin
      if (bus.mem_rd) begin n_rd++; if (first_rd == 0) first_rd = c; end
      if (bus.mem_wr) begin n_wr++; if (first_wr == 0) first_wr = c; end
      if (en_any()) begin
        n_en++;
        if (first_en == 0) begin
          first_en   = c;
          cap_dest   = bus.dest_addr;
          cap_src1   = bus.src1_addr;
          cap_src2   = bus.src2_addr;
          cap_scalar = bus.scalar;
          cap_aos    = bus.add_or_sub;
        end
        bus.unit_done = (n_en == done_at);
      end else begin
        bus.unit_done = stray;
      end
      start = (c == start_at);
      @(negedge clk);
      c++;
    end
    bus.unit_done = 1'b0;
    start         = 1'b0;
    halt_cyc      = c;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bus.unit_done = 1'b0;
    fill(27'h0);
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_busy_halted_fault", {busy, halted, fault}, 3'b000);
    chk("rst_retired", retired, 0);
    chk("rst_pc", bus.instr_addr, 0);
    chk("rst_strobes", {bus.mem_rd, bus.mem_wr, bus.en_add, bus.en_mult, bus.en_scale,
                        bus.en_transpose, bus.add_or_sub}, 0);
    chk("rst_fields", {bus.dest_addr, bus.src1_addr, bus.src2_addr, bus.scalar}, 0);
    reset = 1'b0;
    @(negedge clk);

    // ADD then HALT, unit_done on first EXEC cycle
    fill(mk(OP_HALT, 0, 0, 0));
    imem[0] = mk(OP_ADD, 7'h10, 7'h11, 7'h12);
    run_prog(1, 1'b0, 0, 100);
    chk("add_first_rd", first_rd, 3);
    chk("add_first_en", first_en, 4);
    chk("add_first_wr", first_wr, 5);
    chk("add_rd_wr_counts", {n_rd[7:0], n_wr[7:0]}, {8'd1, 8'd1});
    chk("add_aos", cap_aos, 0);
    chk("add_halt_cyc", halt_cyc, 8);
    chk("add_status", {halted, fault, busy}, 3'b100);
    chk("add_retired", retired, 1);
    chk("add_pc", bus.instr_addr, 1);
    chk("add_state", 32'(dbg_state), 32'(ST_HALT));

    // SUB field latching and add_or_sub during EXEC
    imem[0] = mk(OP_SUB, 7'h05, 7'h01, 7'h02);
    run_prog(1, 1'b0, 0, 100);
    chk("sub_dest", cap_dest, 5);
    chk("sub_src1", cap_src1, 1);
    chk("sub_src2", cap_src2, 2);
    chk("sub_scalar", cap_scalar, 8'h04);
    chk("sub_aos", cap_aos, 1);
    chk("sub_retired", retired, 1);

    // MULT with no unit_done: timeout; a start pulse mid-run is ignored
    imem[0] = mk(OP_MULT, 7'h03, 7'h04, 7'h06);
    run_prog(0, 1'b0, 10, 100);
    chk("to_en_cycles", n_en, 16);
    chk("to_halt_cyc", halt_cyc, 20);
    chk("to_fault", fault, 1);
    chk("to_no_wr", n_wr, 0);
    chk("to_retired", retired, 0);

    // unit_done on the final timeout cycle still completes
    run_prog(16, 1'b0, 0, 100);
    chk("late_en_cycles", n_en, 16);
    chk("late_wr", {n_wr[7:0], first_wr[7:0]}, {8'd1, 8'd20});
    chk("late_halt_cyc", halt_cyc, 23);
    chk("late_fault_cleared", fault, 0);
    chk("late_retired", retired, 1);

    // illegal opcode 01010
    imem[0] = mk(5'b01010, 0, 0, 0);
    run_prog(1, 1'b0, 0, 100);
    chk("ill_halt_cyc", halt_cyc, 3);
    chk("ill_fault", fault, 1);
    chk("ill_retired", retired, 0);
    chk("ill_no_rd", n_rd, 0);

    // sixteen NOPs with stray unit_done held high
    fill(27'h0);
    run_prog(0, 1'b1, 0, 100);
    chk("nop_halt_cyc", halt_cyc, 33);
    chk("nop_retired", retired, 16);
    chk("nop_pc", bus.instr_addr, 15);
    chk("nop_no_mem", {n_rd[7:0], n_wr[7:0], n_en[7:0]}, 0);
    chk("nop_fault", fault, 0);

    // reset during EXEC of SCALE
    fill(mk(OP_HALT, 0, 0, 0));
    imem[0] = mk(OP_SCALE, 7'h22, 7'h33, 7'h44);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("scale_en_before_rst", {bus.en_scale, busy}, 2'b11);
    reset = 1'b1;
    #1;
    chk("scale_rst_enables", {bus.en_add, bus.en_mult, bus.en_scale, bus.en_transpose,
                              bus.mem_rd, bus.mem_wr}, 0);
    chk("scale_rst_status", {busy, halted, fault, retired}, 0);
    chk("scale_rst_fields", {bus.dest_addr, bus.src1_addr, bus.scalar, bus.instr_addr}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    imem[0] = mk(OP_ADD, 7'h01, 7'h02, 7'h03);
    run_prog(1, 1'b0, 0, 100);
    chk("resume_first_rd", first_rd, 3);
    chk("resume_halt_cyc", halt_cyc, 8);
    chk("resume_retired", retired, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
